fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
Single-clock sequencer for the dual-port FIFO memory (DATASIZE × 2^ADDRSIZE register array, combinational read, write gated by wclken/!wfull).
- Owns write/read pointers and full/empty generation, and drives the memory's address/enable/flag pins.
- Adds a registered first-word-fall-through output stage with valid/ready handshakes on both sides, occupancy level, almost-full/almost-empty flags, and synchronous flush.
- Sits between a producer and consumer; a top-level wrapper instantiates fifo_ctrl plus the memory.

Parameters:
DATASIZE, 32, data word width (must match memory)
ADDRSIZE, 6, memory address width; memory depth DEPTH = 2^ADDRSIZE
AF_LEVEL, 60, almost_full asserts when level >= AF_LEVEL (1..DEPTH+1)
AE_LEVEL, 4, almost_empty asserts when level <= AE_LEVEL (0..DEPTH)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all contents
in_valid  in  1  producer has a word
in_ready  out  1  controller accepts word this cycle
in_data  in  DATASIZE  producer word
mem_wdata  out  DATASIZE  to memory wdata (= in_data)
mem_waddr  out  ADDRSIZE  to memory waddr
mem_wclken  out  1  to memory wclken
mem_wfull  out  1  to memory wfull
mem_raddr  out  ADDRSIZE  to memory raddr
mem_rclken  out  1  to memory rclken
mem_rempty  out  1  to memory rempty
mem_rdata  in  DATASIZE  from memory rdata (combinational)
out_valid  out  1  output register holds a word
out_ready  in  1  consumer takes word this cycle
out_data  out  DATASIZE  output register
level  out  ADDRSIZE+1  words held (memory + output register), 0..DEPTH+1
almost_full  out  1  registered, level >= AF_LEVEL
almost_empty  out  1  registered, level <= AE_LEVEL

Behaviour:
- Reset (async, immediate): wptr = rptr = 0, out_valid = 0, out_data = 0, level = 0, almost_full = 0, almost_empty = 1.
- Pointers: wptr and rptr are ADDRSIZE+1 bits; the MSB is the wrap bit.
  - mem_empty = (wptr == rptr).
  - mem_full = low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2^(ADDRSIZE+1).
- Write side:
  - in_ready = !mem_full && !flush, purely from state and flush; no combinational path from out_ready.
  - push = in_valid && in_ready.
  - mem_wclken = push, mem_waddr = wptr[ADDRSIZE-1:0], mem_wfull = mem_full.
  - wptr increments on push.
- Read side (FWFT):
  - load = !mem_empty && (!out_valid || out_ready) && !flush.
  - mem_raddr = rptr[ADDRSIZE-1:0], mem_rclken = load, mem_rempty = mem_empty.
  - On load: out_data <= mem_rdata, rptr increments, out_valid <= 1.
  - pop = out_valid && out_ready. On pop without load: out_valid <= 0.
  - out_data holds its value when no load occurs.
- Latency: a word pushed at edge E into an empty FIFO gives out_valid = 1 after edge E+1 (one cycle). Back-to-back throughput is one word/cycle when out_ready stays high.
- Full: total capacity is DEPTH+1 (memory plus output register).
  - With memory full, in_ready = 0 even if a load/pop happens the same cycle.
  - in_ready rises the cycle after rptr advances.
- Simultaneous push and load on an empty memory: not possible. The load uses the pre-edge empty state, so the word is taken one cycle later.
- level: registered, next = level + push − pop; almost_full and almost_empty are computed from next level and registered.
- flush (sync, highest priority):
  - next edge sets wptr = rptr = 0, out_valid = 0, level = 0, almost_full = 0, almost_empty = 1.
  - During the flush cycle push = 0 and load = 0; in_data is discarded.
  - out_data is not cleared.
- No X propagation: all outputs are defined from reset.

Decomposition:
- Package fifo_pkg:
  - DATASIZE/ADDRSIZE defaults.
  - Function ptr_full(wptr, rptr) and ptr_empty(wptr, rptr) for ADDRSIZE+1-bit pointers, shared with future async FIFO variants.
- One sub-module, fifo_ptr_cnt: an ADDRSIZE+1-bit pointer register with inc and clr inputs; instantiated twice, for write and read.

Test Plan:
- Reset mid-stream (level = 5, out_valid = 1), assert rst asynchronously between edges -> all outputs immediately at reset values; level = 0, almost_empty = 1.
- Push 0xA5A5_0001 into empty FIFO with out_ready = 0 -> mem_wclken = 1, mem_waddr = 0 at that edge; out_valid = 1, out_data = 0xA5A5_0001 one cycle later; level = 1.
- Push 65 words (0..64) with out_ready = 0 -> out_data = 0, in_ready = 0 after the 65th push, mem_wfull = 1, level = 65, almost_full = 1. Further in_valid is ignored (mem_wclken = 0).
- Continuous push/pop for 200 words with out_ready = 1 -> output sequence matches input in order, pointers wrap past 63/127 with no loss or duplication, and level stays ≤ 2.
- From full (level = 65), pop one word -> in_ready = 1 the cycle after rptr advances; a push then brings level back to 65.
- With level = 10, assert flush together with in_valid = 1 -> no write (mem_wclken = 0); next cycle level = 0, out_valid = 0, mem_rempty = 1, and the next pushed word appears at mem_waddr = 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller family: default widths and
// pointer comparison helpers usable by both sync and async variants.
package fifo_pkg;

    localparam int unsigned FIFO_DATASIZE = 32;
    localparam int unsigned FIFO_ADDRSIZE = 6;

    // Pointers are passed zero-extended to 32 bits; only addrsize+1 bits matter.
    function automatic logic ptr_empty(input logic [31:0] wptr,
                                       input logic [31:0] rptr,
                                       input int unsigned addrsize);
        logic [31:0] mask;
        mask = (32'd1 << (addrsize + 1)) - 32'd1;
        return ((wptr ^ rptr) & mask) == '0;
    endfunction

    function automatic logic ptr_full(input logic [31:0] wptr,
                                      input logic [31:0] rptr,
                                      input int unsigned addrsize);
        logic [31:0] mask;
        mask = (32'd1 << (addrsize + 1)) - 32'd1;
        return ((wptr ^ rptr) & mask) == (32'd1 << addrsize);
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit pointer register with synchronous clear taking priority over increment.
module fifo_ptr_cnt #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO sequencer: drives the external register-array memory and
// presents a registered first-word-fall-through output with level/threshold flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE = FIFO_DATASIZE,
    parameter int unsigned ADDRSIZE = FIFO_ADDRSIZE,
    parameter int unsigned AF_LEVEL = 60,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATASIZE-1:0] in_data,
    output logic [DATASIZE-1:0] mem_wdata,
    output logic [ADDRSIZE-1:0] mem_waddr,
    output logic                mem_wclken,
    output logic                mem_wfull,
    output logic [ADDRSIZE-1:0] mem_raddr,
    output logic                mem_rclken,
    output logic                mem_rempty,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATASIZE-1:0] out_data,
    output logic [ADDRSIZE:0]   level,
    output logic                almost_full,
    output logic                almost_empty
);

    localparam int unsigned LW = ADDRSIZE + 1;

    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   rptr;
    logic                mem_full;
    logic                mem_empty;
    logic                push;
    logic                load;
    logic                pop;

    logic                out_valid_q, out_valid_d;
    logic [DATASIZE-1:0] out_data_q,  out_data_d;
    logic [ADDRSIZE:0]   level_q,     level_d;
    logic                af_q,        af_d;
    logic                ae_q,        ae_d;

    assign mem_full  = ptr_full(32'(wptr), 32'(rptr), ADDRSIZE);
    assign mem_empty = ptr_empty(32'(wptr), 32'(rptr), ADDRSIZE);

    // in_ready depends only on state and flush, never on out_ready.
    assign in_ready = !mem_full && !flush;
    assign push     = in_valid && in_ready;
    assign load     = !mem_empty && (!out_valid_q || out_ready) && !flush;
    assign pop      = out_valid_q && out_ready;

    fifo_ptr_cnt #(.W(LW)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wptr)
    );

    fifo_ptr_cnt #(.W(LW)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (load),
        .ptr_o (rptr)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        level_d     = level_q;
        if (flush) begin
            out_valid_d = 1'b0;
            level_d     = '0;
        end else begin
            if (load) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_rdata;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end
            level_d = level_q + LW'(push) - LW'(pop);
        end
        // Thresholds track the next level so the flags line up with level itself.
        af_d = 32'(level_d) >= AF_LEVEL;
        ae_d = 32'(level_d) <= AE_LEVEL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            level_q     <= '0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            level_q     <= level_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
        end
    end

    assign mem_wdata    = in_data;
    assign mem_waddr    = wptr[ADDRSIZE-1:0];
    assign mem_wclken   = push;
    assign mem_wfull    = mem_full;
    assign mem_raddr    = rptr[ADDRSIZE-1:0];
    assign mem_rclken   = load;
    assign mem_rempty   = mem_empty;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural memory attached to the memory pins.
module tb_fifo_ctrl;

    localparam int unsigned DATASIZE = 32;
    localparam int unsigned ADDRSIZE = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATASIZE-1:0] in_data = '0;
    logic [DATASIZE-1:0] mem_wdata;
    logic [ADDRSIZE-1:0] mem_waddr;
    logic                mem_wclken;
    logic                mem_wfull;
    logic [ADDRSIZE-1:0] mem_raddr;
    logic                mem_rclken;
    logic                mem_rempty;
    logic [DATASIZE-1:0] mem_rdata;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [DATASIZE-1:0] out_data;
    logic [ADDRSIZE:0]   level;
    logic                almost_full;
    logic                almost_empty;

    logic [DATASIZE-1:0] mem [64];

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wclken && !mem_wfull) mem[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_raddr];

    fifo_ctrl #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE),
        .AF_LEVEL (60),
        .AE_LEVEL (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mem_wdata    (mem_wdata),
        .mem_waddr    (mem_waddr),
        .mem_wclken   (mem_wclken),
        .mem_wfull    (mem_wfull),
        .mem_raddr    (mem_raddr),
        .mem_rclken   (mem_rclken),
        .mem_rempty   (mem_rempty),
        .mem_rdata    (mem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] expw;
        int unsigned sent;
        int unsigned received;
        int unsigned cycles;
        int unsigned maxlvl;

        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rempty", 32'(mem_rempty), 32'd1);

        // single word latency
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0001;
        #1;
        chk("w1_wclken", 32'(mem_wclken), 32'd1);
        chk("w1_waddr", 32'(mem_waddr), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("w1_level", 32'(level), 32'd1);
        chk("w1_valid_early", 32'(out_valid), 32'd0);
        tick();
        chk("w1_valid", 32'(out_valid), 32'd1);
        chk("w1_data", out_data, 32'hA5A5_0001);

        // flush keeps out_data, then fill to capacity
        do_flush();
        chk("fl0_valid", 32'(out_valid), 32'd0);
        chk("fl0_data_kept", out_data, 32'hA5A5_0001);
        for (int i = 0; i < 65; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            tick();
        end
        in_data = 32'h99;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_wfull", 32'(mem_wfull), 32'd1);
        chk("full_wclken", 32'(mem_wclken), 32'd0);
        chk("full_level", 32'(level), 32'd65);
        chk("full_af", 32'(almost_full), 32'd1);
        chk("full_ae", 32'(almost_empty), 32'd0);
        chk("full_out_data", out_data, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("full_level_hold", 32'(level), 32'd65);

        // pop one from full
        out_ready = 1'b1;
        #1;
        chk("pop_in_ready_pre", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("pop_out_data", out_data, 32'd1);
        chk("pop_level", 32'(level), 32'd64);
        chk("pop_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 32'd65;
        #1;
        chk("refill_wclken", 32'(mem_wclken), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("refill_level", 32'(level), 32'd65);
        chk("refill_in_ready", 32'(in_ready), 32'd0);

        // flush with a concurrent push at level 10
        do_flush();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(100 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("l10_level", 32'(level), 32'd10);
        chk("l10_ae", 32'(almost_empty), 32'd0);
        chk("l10_out_data", out_data, 32'd100);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h777;
        #1;
        chk("flush_wclken", 32'(mem_wclken), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_rempty", 32'(mem_rempty), 32'd1);
        chk("flush_ae", 32'(almost_empty), 32'd1);
        chk("flush_af", 32'(almost_full), 32'd0);
        chk("flush_data_kept", out_data, 32'd100);
        in_valid = 1'b1;
        in_data  = 32'h0000_BEEF;
        #1;
        chk("post_flush_waddr", 32'(mem_waddr), 32'd0);
        chk("post_flush_wclken", 32'(mem_wclken), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_flush_data", out_data, 32'h0000_BEEF);
        chk("post_flush_level", 32'(level), 32'd1);

        // streaming with wrap-around
        do_flush();
        sent = 0;
        received = 0;
        cycles = 0;
        maxlvl = 0;
        out_ready = 1'b1;
        while (received < 200 && cycles < 600) begin
            in_valid = (sent < 200);
            in_data  = 32'hC000_0000 + sent;
            #1;
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            if (out_valid && out_ready) begin
                expw = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
                chk("stream_data", out_data, expw);
                received++;
            end
            if (32'(level) > maxlvl) maxlvl = 32'(level);
            tick();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_count", received, 32'd200);
        chk("stream_leftover", q.size(), 32'd0);
        chk("stream_maxlvl_le2", 32'(maxlvl <= 2), 32'd1);

        // asynchronous reset mid-stream
        do_flush();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(200 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd5);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ae", 32'(almost_empty), 32'd1);
        chk("arst_af", 32'(almost_full), 32'd0);
        chk("arst_rempty", 32'(mem_rempty), 32'd1);
        #1 rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
